// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared register.
// A requester may lock ownership for a bounded run of writes.
module shared_reg_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                     locked
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam bit CAN_LOCK = (MAX_LOCK > 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t state, state_nxt;

  logic [IW-1:0]      ptr, ptr_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic [NUM_REQ-1:0] ack_nxt;
  logic [IW-1:0]      owner_nxt;
  logic [IW-1:0]      win;
  logic               win_vld;
  logic [IW:0]        idx;
  logic               own_exit;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (x == IW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // first requester at or after ptr, wrapping
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_REQ))
        idx = idx - (IW+1)'(NUM_REQ);
      if (!win_vld && req[idx[IW-1:0]]) begin
        win_vld = 1'b1;
        win     = idx[IW-1:0];
      end
    end
  end

  assign own_exit = !lock[owner] ||
                    (cnt >= CW'(MAX_LOCK - 1));

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      q     <= '0;
      ack   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
      ack   <= ack_nxt;
      owner <= owner_nxt;
    end
  end

  // next-state selection
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (win_vld && lock[win] && CAN_LOCK)
          state_nxt = OWNED;
      OWNED:
        if (own_exit)
          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // write, ack, pointer and lock-count updates
  always_comb begin
    q_nxt     = q;
    ack_nxt   = '0;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          q_nxt        = wdata[int'(win)*WIDTH +: WIDTH];
          ack_nxt[win] = 1'b1;
          ptr_nxt      = inc(win);
          if (lock[win] && CAN_LOCK) begin
            owner_nxt = win;
            cnt_nxt   = CW'(1);
          end
        end
      end
      OWNED: begin
        cnt_nxt = cnt + 1'b1;
        if (req[owner]) begin
          q_nxt          = wdata[int'(owner)*WIDTH +: WIDTH];
          ack_nxt[owner] = 1'b1;
        end
        if (own_exit) begin
          ptr_nxt = inc(owner);
          cnt_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  assign locked = (state == OWNED);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter.
// Checks round-robin order, wrap, lock, timeout and reset.
module tb_shared_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        locked;

  int n_chk  = 0;
  int n_pass = 0;

  shared_reg_arbiter #(
    .NUM_REQ(4), .WIDTH(8), .MAX_LOCK(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .wdata(wdata), .ack(ack), .q(q),
    .owner(owner), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    req   = 4'b1111;
    lock  = 4'b0000;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};

    // reset held two cycles with all requests up
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_q", q, 8'h00);
      chk("rst_ack", ack, 4'b0000);
      chk("rst_locked", locked, 1'b0);
    end
    rst = 1'b0;
    req = 4'b0000;
    step();
    chk("idle_ack", ack, 4'b0000);
    chk("idle_q", q, 8'h00);

    // round robin from ptr 0
    req = 4'b1111;
    step();
    chk("rr0_ack", ack, 4'b0001);
    chk("rr0_q", q, 8'h11);
    req = 4'b1110;
    step();
    chk("rr1_ack", ack, 4'b0010);
    chk("rr1_q", q, 8'h22);
    req = 4'b1100;
    step();
    chk("rr2_ack", ack, 4'b0100);
    chk("rr2_q", q, 8'h33);
    req = 4'b1000;
    step();
    chk("rr3_ack", ack, 4'b1000);
    chk("rr3_q", q, 8'h44);
    req = 4'b0000;
    step();
    chk("hold_ack", ack, 4'b0000);
    chk("hold_q", q, 8'h44);

    // move ptr to 3, then wrap
    req = 4'b0100;
    step();
    chk("pre_wrap_ack", ack, 4'b0100);
    req = 4'b1001;
    step();
    chk("wrap3_ack", ack, 4'b1000);
    chk("wrap3_q", q, 8'h44);
    req = 4'b0001;
    step();
    chk("wrap0_ack", ack, 4'b0001);
    chk("wrap0_q", q, 8'h11);
    req = 4'b0000;

    // lock by requester 1 while 0 waits (ptr=1)
    req   = 4'b0011;
    lock  = 4'b0010;
    wdata = {8'h44, 8'h33, 8'hA1, 8'h11};
    step();
    chk("lk1_ack", ack, 4'b0010);
    chk("lk1_q", q, 8'hA1);
    chk("lk1_locked", locked, 1'b1);
    chk("lk1_owner", owner, 2'd1);
    wdata[15:8] = 8'hA2;
    step();
    chk("lk2_ack", ack, 4'b0010);
    chk("lk2_q", q, 8'hA2);
    wdata[15:8] = 8'hA3;
    step();
    chk("lk3_ack", ack, 4'b0010);
    chk("lk3_q", q, 8'hA3);
    chk("lk3_locked", locked, 1'b1);
    req  = 4'b0001;
    lock = 4'b0000;
    step();
    chk("lkx_ack", ack, 4'b0000);
    chk("lkx_locked", locked, 1'b0);
    chk("lkx_q", q, 8'hA3);
    step();
    chk("lk_next_ack", ack, 4'b0001);
    chk("lk_next_q", q, 8'h11);
    req = 4'b0000;

    // timeout: req2 locks forever, req3 waits (ptr=1)
    req   = 4'b1100;
    lock  = 4'b0100;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("to%0d_ack", i), ack, 4'b0100);
      chk($sformatf("to%0d_locked", i), locked,
          (i < 8) ? 1'b1 : 1'b0);
    end
    step();
    chk("to_next_ack", ack, 4'b1000);
    chk("to_next_q", q, 8'h44);
    chk("to_next_locked", locked, 1'b0);
    req  = 4'b0000;
    lock = 4'b0000;
    step();

    // reset in the middle of a lock (ptr=0)
    req  = 4'b0010;
    lock = 4'b0010;
    step();
    chk("ml_ack", ack, 4'b0010);
    chk("ml_locked", locked, 1'b1);
    chk("ml_q", q, 8'h22);
    req = 4'b0000;
    step();
    chk("ml_hold_ack", ack, 4'b0000);
    chk("ml_hold_locked", locked, 1'b1);
    rst = 1'b1;
    step();
    chk("ml_rst_locked", locked, 1'b0);
    chk("ml_rst_q", q, 8'h00);
    chk("ml_rst_ack", ack, 4'b0000);
    rst  = 1'b0;
    lock = 4'b0000;
    req  = 4'b0100;
    step();
    chk("post_rst_ack", ack, 4'b0100);
    chk("post_rst_q", q, 8'h33);
    chk("post_rst_locked", locked, 1'b0);
    req = 4'b0000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
